// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101
  } imm_src_t;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate extraction; selectors 110/111 flag ImmErr.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmErr
);

  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  // Signed formats pre-fill with the sign bit, then overwrite the low field.
  always_comb begin
    ImmExt = '0;
    ImmErr = 1'b0;
    case (imm_src_t'(ImmSrc))
      IMM_I: begin
        ImmExt       = {XLEN{Instr[31]}};
        ImmExt[11:0] = Instr[31:20];
      end
      IMM_S: begin
        ImmExt       = {XLEN{Instr[31]}};
        ImmExt[11:0] = {Instr[31:25], Instr[11:7]};
      end
      IMM_B: begin
        ImmExt       = {XLEN{Instr[31]}};
        ImmExt[12:0] = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      end
      IMM_J: begin
        ImmExt       = {XLEN{Instr[31]}};
        ImmExt[20:0] = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      end
      IMM_U: begin
        ImmExt       = {XLEN{Instr[31]}};
        ImmExt[31:0] = {Instr[31:12], 12'h000};
      end
      IMM_SHAMT: begin
        if (XLEN == XLEN_64) ImmExt[5:0] = Instr[25:20];
        else                 ImmExt[4:0] = Instr[24:20];
      end
      default: ImmErr = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid (OReg + SReg) and tag sideband.
// Define IMM_ERRCNT_EN to build the saturating illegal-selector counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] TagIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ImmExt,
  output logic             ImmErr,
  output logic [TAG_W-1:0] TagOut,
  input  logic             ErrClr,
  output logic [CNT_W-1:0] ErrCount
);

  if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .Instr  (Instr),
    .ImmSrc (ImmSrc),
    .ImmExt (dec_imm),
    .ImmErr (dec_err)
  );

  logic             ov_q, ov_d, sv_q, sv_d;
  logic [XLEN-1:0]  oimm_q, oimm_d, simm_q, simm_d;
  logic             oerr_q, oerr_d, serr_q, serr_d;
  logic [TAG_W-1:0] otag_q, otag_d, stag_q, stag_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = InValid & ~sv_q;
  assign out_xfer = ov_q & OutReady;

  // SReg only fills when OReg is stalled, so InReady never depends on OutReady.
  always_comb begin
    ov_d   = ov_q;   oimm_d = oimm_q; oerr_d = oerr_q; otag_d = otag_q;
    sv_d   = sv_q;   simm_d = simm_q; serr_d = serr_q; stag_d = stag_q;
    if (sv_q) begin
      if (out_xfer) begin
        oimm_d = simm_q; oerr_d = serr_q; otag_d = stag_q;
        sv_d   = 1'b0;
      end
    end else if (!ov_q || out_xfer) begin
      ov_d = in_xfer;
      if (in_xfer) begin
        oimm_d = dec_imm; oerr_d = dec_err; otag_d = TagIn;
      end
    end else if (in_xfer) begin
      sv_d   = 1'b1;
      simm_d = dec_imm; serr_d = dec_err; stag_d = TagIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0; oimm_q <= '0; oerr_q <= 1'b0; otag_q <= '0;
      sv_q <= 1'b0; simm_q <= '0; serr_q <= 1'b0; stag_q <= '0;
    end else begin
      ov_q <= ov_d; oimm_q <= oimm_d; oerr_q <= oerr_d; otag_q <= otag_d;
      sv_q <= sv_d; simm_q <= simm_d; serr_q <= serr_d; stag_q <= stag_d;
    end
  end

  assign InReady  = ~sv_q;
  assign OutValid = ov_q;
  assign ImmExt   = oimm_q;
  assign ImmErr   = oerr_q;
  assign TagOut   = otag_q;

`ifdef IMM_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ErrClr)                               cnt_d = '0;
    else if (in_xfer && dec_err && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ErrCount = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = ErrClr;
  assign ErrCount   = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;

  localparam int TAG_W = 8;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, out_ready, err_clr;
  logic [31:0]       instr;
  logic [2:0]        imm_src;
  logic [TAG_W-1:0]  tag_in;

  logic              in_ready, out_valid, err32;
  logic [31:0]       imm32;
  logic [TAG_W-1:0]  tag32;
  logic [CNT_W-1:0]  cnt32;

  logic              in_ready64, out_valid64, err64;
  logic [63:0]       imm64;
  logic [TAG_W-1:0]  tag64;
  logic [CNT_W-1:0]  cnt64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]      ins;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(in_ready),
    .Instr(instr), .ImmSrc(imm_src), .TagIn(tag_in),
    .OutValid(out_valid), .OutReady(out_ready), .ImmExt(imm32), .ImmErr(err32),
    .TagOut(tag32), .ErrClr(err_clr), .ErrCount(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(in_ready64),
    .Instr(instr), .ImmSrc(imm_src), .TagIn(tag_in),
    .OutValid(out_valid64), .OutReady(out_ready), .ImmExt(imm64), .ImmErr(err64),
    .TagOut(tag64), .ErrClr(err_clr), .ErrCount(cnt64)
  );

  // Reference immediate computed with arithmetic shifts on the sign-extended word.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input bit x64);
    longint s, v;
    s = longint'($signed(ins));
    case (src)
      3'd0: v = s >>> 20;
      3'd1: v = ((s >>> 25) <<< 5) | longint'((ins >> 7) & 32'h1F);
      3'd2: v = ((s >>> 31) <<< 12) | longint'(((ins >> 7) & 32'h1) << 11)
              | longint'(((ins >> 25) & 32'h3F) << 5) | longint'(((ins >> 8) & 32'hF) << 1);
      3'd3: v = ((s >>> 31) <<< 20) | longint'(((ins >> 12) & 32'hFF) << 12)
              | longint'(((ins >> 20) & 32'h1) << 11) | longint'(((ins >> 21) & 32'h3FF) << 1);
      3'd4: v = (s >>> 12) <<< 12;
      3'd5: v = x64 ? longint'((ins >> 20) & 32'h3F) : longint'((ins >> 20) & 32'h1F);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic int exp_count(input int n_illegal);
`ifdef IMM_ERRCNT_EN
    return (n_illegal > SAT) ? SAT : n_illegal;
`else
    return 0 * n_illegal;
`endif
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b expected 1", in_ready); end
    checks++; if (imm32 !== 32'h0 || err32 !== 1'b0) begin errors++; $display("FAIL reset_imm: got %h/%b expected 0/0", imm32, err32); end
    checks++; if (tag32 !== '0 || cnt32 !== '0) begin errors++; $display("FAIL reset_tag_cnt: got %h/%h expected 0/0", tag32, cnt32); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ins [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'hFFFFF0B7, 32'h03F00013, 32'h7FF00093};
    logic [2:0]  src [6] = '{3'd0, 3'd2, 3'd4, 3'd4, 3'd5, 3'd0};
    logic [31:0] e32 [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFF000, 32'h0000001F, 32'h000007FF};
    logic [63:0] e64 [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
                             64'hFFFFFFFFFFFFF000, 64'h000000000000003F, 64'h00000000000007FF};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; instr = ins[k]; imm_src = src[k];
      tag_in = TAG_W'(8'h40 + k);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (imm32 !== e32[k]) begin errors++; $display("FAIL dir_imm32[%0d]: got %h expected %h", k, imm32, e32[k]); end
      checks++; if (imm64 !== e64[k]) begin errors++; $display("FAIL dir_imm64[%0d]: got %h expected %h", k, imm64, e64[k]); end
      checks++; if (err32 !== 1'b0 || tag32 !== TAG_W'(8'h40 + k)) begin errors++; $display("FAIL dir_err_tag[%0d]: got %b/%h expected 0/%h", k, err32, tag32, 8'h40 + k); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093; imm_src = 3'd0; tag_in = 8'h11;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || tag32 !== 8'h11) begin errors++; $display("FAIL bp_A_loaded: got rdy=%b vld=%b tag=%h expected 1/1/11", in_ready, out_valid, tag32); end
    instr = 32'h00200093; tag_in = 8'h22;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || tag32 !== 8'h11) begin errors++; $display("FAIL bp_B_skid: got rdy=%b tag=%h expected 0/11", in_ready, tag32); end
    instr = 32'h00300093; tag_in = 8'h33;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || tag32 !== 8'h11 || imm32 !== 32'h1) begin errors++; $display("FAIL bp_stall: got rdy=%b vld=%b tag=%h imm=%h expected 0/1/11/1", in_ready, out_valid, tag32, imm32); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || tag32 !== 8'h22 || imm32 !== 32'h2 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_B_out: got vld=%b tag=%h imm=%h rdy=%b expected 1/22/2/1", out_valid, tag32, imm32, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || tag32 !== 8'h33 || imm32 !== 32'h3) begin errors++; $display("FAIL bp_C_out: got vld=%b tag=%h imm=%h expected 1/33/3", out_valid, tag32, imm32); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drained: got vld=%b rdy=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_errcnt();
    @(negedge clk);
    err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1 || imm32 !== 32'h0 || err32 !== 1'b1) begin errors++; $display("FAIL err_item[%0d]: got vld=%b imm=%h err=%b expected 1/0/1", k, out_valid, imm32, err32); end
        checks++; if (err64 !== 1'b1 || imm64 !== 64'h0) begin errors++; $display("FAIL err_item64[%0d]: got imm=%h err=%b expected 0/1", k, imm64, err64); end
        checks++; if (int'(cnt32) !== ((k == 6) ? 0 : exp_count(k))) begin errors++; $display("FAIL err_count[%0d]: got %0d expected %0d", k, cnt32, (k == 6) ? 0 : exp_count(k)); end
      end
      if (k < 6) begin
        in_valid = 1'b1; instr = $urandom; imm_src = (k % 2 == 0) ? 3'd6 : 3'd7;
        tag_in = TAG_W'(8'h80 + k); err_clr = (k == 5);
      end else begin
        in_valid = 1'b0; err_clr = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    int    cnt_m = 0;
    bit    iv, or_, ix, ox;
    item_t it;
    logic [63:0] r32, r64;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      iv  = (cyc < 392) && ($urandom_range(0, 2) != 0);
      or_ = (cyc >= 392) || ($urandom_range(0, 3) != 0);
      in_valid = iv; out_ready = or_;
      instr = $urandom; imm_src = 3'($urandom_range(0, 7)); tag_in = TAG_W'($urandom);
      err_clr = ($urandom_range(0, 19) == 0);
      #4;
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_outvalid@%0d: got %b expected %b", cyc, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_inready@%0d: got %b expected %b", cyc, in_ready, q.size() < 2); end
      checks++; if (int'(cnt32) !== cnt_m) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, cnt32, cnt_m); end
      ix = iv && (q.size() < 2);
      ox = or_ && (q.size() > 0);
      if (ox) begin
        it  = q.pop_front();
        r32 = ref_imm(it.ins, it.src, 1'b0);
        r64 = ref_imm(it.ins, it.src, 1'b1);
        checks++; if (imm32 !== r32[31:0]) begin errors++; $display("FAIL rnd_imm32@%0d: got %h expected %h (src %0d ins %h)", cyc, imm32, r32[31:0], it.src, it.ins); end
        checks++; if (imm64 !== r64) begin errors++; $display("FAIL rnd_imm64@%0d: got %h expected %h (src %0d ins %h)", cyc, imm64, r64, it.src, it.ins); end
        checks++; if (err32 !== (it.src >= 3'd6) || tag32 !== it.tag) begin errors++; $display("FAIL rnd_err_tag@%0d: got %b/%h expected %b/%h", cyc, err32, tag32, it.src >= 3'd6, it.tag); end
      end
      if (ix) q.push_back('{ins: instr, src: imm_src, tag: tag_in});
`ifdef IMM_ERRCNT_EN
      if (err_clr) cnt_m = 0;
      else if (ix && imm_src >= 3'd6 && cnt_m < SAT) cnt_m++;
`endif
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d items left expected 0", q.size()); end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093; imm_src = 3'd0; tag_in = 8'h5A;
    @(negedge clk);
    tag_in = 8'h5B;
    @(negedge clk);
    tag_in = 8'h5C;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_full: got rdy=%b vld=%b expected 0/1", in_ready, out_valid); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_async: got vld=%b rdy=%b expected 0/1", out_valid, in_ready); end
    checks++; if (imm32 !== 32'h0 || tag32 !== '0 || err32 !== 1'b0 || cnt32 !== '0) begin errors++; $display("FAIL rm_fields: got imm=%h tag=%h err=%b cnt=%h expected 0", imm32, tag32, err32, cnt32); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || out_valid64 !== 1'b0) begin errors++; $display("FAIL rm_held: got %b/%b expected 0/0", out_valid, out_valid64); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_stale[%0d]: got vld=%b rdy=%b expected 0/1", k, out_valid, in_ready); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    instr = '0; imm_src = '0; tag_in = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_errcnt();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, flow-controlled immediate generator for the decode stage.
- Extracts and extends the RV32I/RV64I immediate (I, S, B, J, U, shift-amount) selected by ImmSrc.
- Valid/ready handshake on both sides, with a 2-entry skid so it sustains one item per cycle under backpressure.
- Carries a sideband tag (e.g. PC/rd), flags illegal selectors instead of emitting a magic value, and optionally counts them.

Parameters:
- XLEN, 32, output width; legal values 32 or 64.
- TAG_W, 8, sideband tag width carried alongside each item.
- CNT_W, 8, width of the saturating illegal-selector counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- InValid  in  1  input item valid.
- InReady  out  1  block can accept an item.
- Instr  in  32  raw instruction word.
- ImmSrc  in  3  format select (see Behaviour).
- TagIn  in  TAG_W  sideband, passed through unchanged.
- OutValid  out  1  output item valid.
- OutReady  in  1  consumer accepts the item.
- ImmExt  out  XLEN  extended immediate.
- ImmErr  out  1  item had an illegal ImmSrc.
- TagOut  out  TAG_W  tag of the output item.
- ErrClr  in  1  synchronous clear of ErrCount.
- ErrCount  out  CNT_W  saturating count of accepted illegal items.

Behaviour:
- Decode (combinational; every signed format sign-extends from Instr[31] to XLEN):
  - 000 I: Instr[31:20].
  - 001 S: {Instr[31:25], Instr[11:7]}.
  - 010 B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - 011 J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - 100 U: {Instr[31:12], 12'b0}, sign-extended for XLEN=64.
  - 101 SHAMT: zero-extended Instr[24:20] (XLEN=32) or Instr[25:20] (XLEN=64).
  - 110/111: ImmExt=0, ImmErr=1.
- Handshake:
  - Input transfer when InValid&&InReady.
  - Output transfer when OutValid&&OutReady.
- Storage: output register (OReg) plus skid register (SReg).
- InReady = !SReg.valid, driven from a register with no combinational path from OutReady.
- Latency: 1 cycle from input transfer to OutValid when OReg is empty or draining.
- Per-cycle update:
  - OReg empty or transferring, SReg empty: input (if any) loads OReg.
  - OReg full and not transferring, input arrives: input loads SReg; InReady=0 from next cycle.
  - SReg full and OReg transferring: SReg moves to OReg; InReady=1 from next cycle.
  - Output fields stay stable while OutValid && !OutReady.
  - Strict FIFO order; no loss, no duplication.
- Reset (async, rst_n low), immediate and held until release:
  - OutValid=0, SReg.valid=0, InReady=1.
  - ImmExt=0, ImmErr=0, TagOut=0, ErrCount=0.
  - Input ignored while in reset.
  - Reset mid-operation discards both buffered items.
- ErrCount:
  - Increments on an input transfer with ImmSrc in {110,111}.
  - Saturates at 2^CNT_W-1.
  - ErrClr has priority over a same-cycle increment; result is 0.
- XLEN other than 32/64: elaboration error.

Optional Feature:
- IMM_ERRCNT_EN defined: saturating counter and ErrClr logic are instantiated as above.
- Undefined: no counter flops; ErrCount tied to 0 and ErrClr ignored; ports remain present.
- ImmErr per item is unaffected by the macro.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_src_t: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT.
  - Constants for legal XLEN values.
- Sub-module imm_decode: purely combinational, parameter XLEN; Instr and ImmSrc in, ImmExt and ImmErr out.
- imm_gen_pipe owns the OReg/SReg skid logic and the counter.

Test Plan:
- XLEN=32, Instr=FFF00093, ImmSrc=000, OutReady=1: OutValid one cycle later, ImmExt=FFFFFFFF, ImmErr=0, TagOut=TagIn.
- Instr=FE000EE3 (beq -4), ImmSrc=010: ImmExt=FFFFFFFC.
- ImmSrc=100 with Instr=123450B7: ImmExt=12345000. With XLEN=64 and Instr=FFFFF0B7: ImmExt=FFFFFFFFFFFFF000.
- OutReady=0, three back-to-back items A,B,C:
  - A held in OReg, B in SReg, InReady=0 the cycle after B; C stalls.
  - Raise OutReady: A,B,C emerge in order on consecutive cycles; InReady returns to 1.
- CNT_W=2 with IMM_ERRCNT_EN, five items with ImmSrc=110: each gives ImmExt=0, ImmErr=1; ErrCount=3 (saturated). ErrClr together with a sixth illegal item: ErrCount=0.
- Both OReg and SReg full, rst_n pulsed low mid-cycle: OutValid=0 and InReady=1 immediately; no stale item after release.
